// File: rtl/pc_sequencer_pkg.sv
// Shared types and sizing helpers for the program-counter run-control sequencer.
package pc_seq_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    FAULT
  } state_t;

  // One extra bit so a full stack (sp == DEPTH) is representable.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/program_counter side of the sequencer: instruction decode in, PC control out.
interface pc_sequencer_if #(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0] rp;
  logic              call_instr;
  logic              ret_instr;
  logic              halt_instr;
  logic [ADDR_W-1:0] call_target;
  logic              start;
  logic [ADDR_W-1:0] start_address;
  logic              jump2sub;
  logic [ADDR_W-1:0] subroutine;

  modport master (
    output rp, call_instr, ret_instr, halt_instr, call_target,
    input  start, start_address, jump2sub, subroutine
  );

  modport slave (
    input  rp, call_instr, ret_instr, halt_instr, call_target,
    output start, start_address, jump2sub, subroutine
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; entries are plain registers written only on push.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int SP_W = sp_width(DEPTH);

  logic [SP_W-1:0]   sp_reg;
  logic [SP_W-2:0]   top_idx;
  logic [ADDR_W-1:0] mem [DEPTH];

  assign full    = (sp_reg == SP_W'(DEPTH));
  assign empty   = (sp_reg == '0);
  assign top_idx = sp_reg[SP_W-2:0] - (SP_W-1)'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_reg <= '0;
    end else if (clr) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + SP_W'(1);
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - SP_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDR_W-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (push && !full && (sp_reg == SP_W'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Run-control FSM for program_counter plus call/return linkage through jump2sub.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] prog_addr,
  output logic              busy,
  output logic              done,
  output logic              stack_err,
  pc_sequencer_if.slave     bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] start_address_reg;
  logic              stack_err_reg;

  logic              in_run, accept, fault, push, pop;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  // Halt outranks call/ret; illegal stack use faults without touching the stack.
  assign in_run = (state_reg == RUN);
  assign accept = (state_reg == IDLE) && req;
  assign fault  = in_run && !bus.halt_instr &&
                  ((bus.call_instr && bus.ret_instr) ||
                   (bus.call_instr && stk_full) ||
                   (bus.ret_instr && stk_empty));
  assign push   = in_run && !bus.halt_instr && bus.call_instr && !bus.ret_instr && !stk_full;
  assign pop    = in_run && !bus.halt_instr && bus.ret_instr && !bus.call_instr && !stk_empty;

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .push      (push),
    .pop       (pop),
    .push_data (bus.rp + ADDR_W'(1)),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      start_address_reg <= '0;
      stack_err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        start_address_reg <= prog_addr;
        stack_err_reg     <= 1'b0;
      end else if (fault) begin
        stack_err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN: begin
        if (bus.halt_instr) state_next = DONE;
        else if (fault)     state_next = FAULT;
      end
      DONE:    if (!req) state_next = IDLE;
      FAULT:   if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.start         = (state_reg != RUN);
    bus.start_address = start_address_reg;
    bus.jump2sub      = push || pop;
    bus.subroutine    = '0;
    if (push)     bus.subroutine = bus.call_target;
    else if (pop) bus.subroutine = stk_top;
    busy      = (state_reg == LOAD) || (state_reg == RUN);
    done      = (state_reg == DONE);
    stack_err = stack_err_reg;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: table-driven run plus nested-call and reset sequences.
module tb_pc_sequencer;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic [ADDR_W-1:0] prog_addr;
  logic              busy, done, stack_err;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .prog_addr (prog_addr),
    .busy      (busy),
    .done      (done),
    .stack_err (stack_err),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              req;
    logic [ADDR_W-1:0] prog;
    logic [ADDR_W-1:0] rp;
    logic              call;
    logic              ret;
    logic              halt;
    logic [ADDR_W-1:0] tgt;
    logic              e_start;
    logic [ADDR_W-1:0] e_sa;
    logic              e_j;
    logic [ADDR_W-1:0] e_sub;
    logic              e_busy;
    logic              e_done;
    logic              e_err;
  } vec_t;

  vec_t vecs [25];

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] rpv,
                       input logic c, input logic rt, input logic h, input logic [ADDR_W-1:0] t);
    @(negedge clk);
    req             = r;
    prog_addr       = p;
    bus.rp          = rpv;
    bus.call_instr  = c;
    bus.ret_instr   = rt;
    bus.halt_instr  = h;
    bus.call_target = t;
    #1;
  endtask

  task automatic expect_out(input string name, input logic st, input logic [ADDR_W-1:0] sa,
                            input logic j, input logic [ADDR_W-1:0] sub,
                            input logic b, input logic d, input logic e);
    logic [24:0] act, exp;
    act = {bus.start, bus.start_address, bus.jump2sub, bus.subroutine, busy, done, stack_err};
    exp = {st, sa, j, sub, b, d, e};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got start=%b sa=%h j2s=%b sub=%h busy=%b done=%b err=%b, need start=%b sa=%h j2s=%b sub=%h busy=%b done=%b err=%b",
               name, act[24], act[23:14], act[13], act[12:3], act[2], act[1], act[0],
               st, sa, j, sub, b, d, e);
    end else begin
      $display("ok   %s: start=%b sa=%h j2s=%b sub=%h busy=%b done=%b err=%b",
               name, st, sa, j, sub, b, d, e);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] rpv,
                              input logic c, input logic rt, input logic h, input logic [ADDR_W-1:0] t,
                              input logic es, input logic [ADDR_W-1:0] esa, input logic ej,
                              input logic [ADDR_W-1:0] esub, input logic eb, input logic ed, input logic ee);
    vec_t v;
    v = '{r, p, rpv, c, rt, h, t, es, esa, ej, esub, eb, ed, ee};
    return v;
  endfunction

  initial begin
    //               req prog    rp      c  r  h  tgt     st sa      j  sub     b  d  e
    vecs[0]  = mk(0, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h000, 0, 10'h000, 0, 0, 0);
    vecs[1]  = mk(1, 10'h040, 10'h000, 0, 0, 0, 10'h000, 1, 10'h000, 0, 10'h000, 0, 0, 0);
    vecs[2]  = mk(1, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h040, 0, 10'h000, 1, 0, 0);
    vecs[3]  = mk(1, 10'h000, 10'h040, 0, 0, 0, 10'h000, 0, 10'h040, 0, 10'h000, 1, 0, 0);
    vecs[4]  = mk(1, 10'h000, 10'h045, 1, 0, 0, 10'h200, 0, 10'h040, 1, 10'h200, 1, 0, 0);
    vecs[5]  = mk(1, 10'h000, 10'h200, 0, 0, 0, 10'h000, 0, 10'h040, 0, 10'h000, 1, 0, 0);
    vecs[6]  = mk(1, 10'h000, 10'h201, 0, 1, 0, 10'h000, 0, 10'h040, 1, 10'h046, 1, 0, 0);
    vecs[7]  = mk(1, 10'h000, 10'h046, 0, 1, 0, 10'h000, 0, 10'h040, 0, 10'h000, 1, 0, 0);
    vecs[8]  = mk(1, 10'h000, 10'h000, 1, 0, 0, 10'h123, 1, 10'h040, 0, 10'h000, 0, 0, 1);
    vecs[9]  = mk(0, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h040, 0, 10'h000, 0, 0, 1);
    vecs[10] = mk(0, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h040, 0, 10'h000, 0, 0, 1);
    vecs[11] = mk(1, 10'h3FE, 10'h000, 0, 0, 0, 10'h000, 1, 10'h040, 0, 10'h000, 0, 0, 1);
    vecs[12] = mk(1, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h3FE, 0, 10'h000, 1, 0, 0);
    vecs[13] = mk(1, 10'h000, 10'h3FF, 1, 0, 0, 10'h010, 0, 10'h3FE, 1, 10'h010, 1, 0, 0);
    vecs[14] = mk(1, 10'h000, 10'h010, 0, 1, 0, 10'h000, 0, 10'h3FE, 1, 10'h000, 1, 0, 0);
    vecs[15] = mk(1, 10'h000, 10'h000, 1, 1, 0, 10'h155, 0, 10'h3FE, 0, 10'h000, 1, 0, 0);
    vecs[16] = mk(1, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h3FE, 0, 10'h000, 0, 0, 1);
    vecs[17] = mk(0, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h3FE, 0, 10'h000, 0, 0, 1);
    vecs[18] = mk(1, 10'h100, 10'h000, 0, 0, 0, 10'h000, 1, 10'h3FE, 0, 10'h000, 0, 0, 1);
    vecs[19] = mk(1, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h100, 0, 10'h000, 1, 0, 0);
    vecs[20] = mk(1, 10'h000, 10'h100, 1, 0, 1, 10'h300, 0, 10'h100, 0, 10'h000, 1, 0, 0);
    vecs[21] = mk(1, 10'h000, 10'h000, 0, 1, 0, 10'h000, 1, 10'h100, 0, 10'h000, 0, 1, 0);
    vecs[22] = mk(1, 10'h000, 10'h000, 1, 0, 0, 10'h000, 1, 10'h100, 0, 10'h000, 0, 1, 0);
    vecs[23] = mk(0, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h100, 0, 10'h000, 0, 1, 0);
    vecs[24] = mk(0, 10'h000, 10'h000, 0, 0, 0, 10'h000, 1, 10'h100, 0, 10'h000, 0, 0, 0);

    rst_n = 1'b0;
    req = 1'b0; prog_addr = '0;
    bus.rp = '0; bus.call_instr = 1'b0; bus.ret_instr = 1'b0;
    bus.halt_instr = 1'b0; bus.call_target = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1, 10'h000, 0, 10'h000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].req, vecs[i].prog, vecs[i].rp, vecs[i].call, vecs[i].ret, vecs[i].halt, vecs[i].tgt);
      expect_out($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_sa, vecs[i].e_j,
                 vecs[i].e_sub, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
    end

    // Nested calls: fill, drain in LIFO order, refill, then overflow.
    drive(1, 10'h200, 0, 0, 0, 0, 0);
    expect_out("nest_accept", 1, 10'h100, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    expect_out("nest_load", 1, 10'h200, 0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 10'(16 * i + 5), 1, 0, 0, 10'(256 + i));
      expect_out($sformatf("nest_call%0d", i), 0, 10'h200, 1, 10'(256 + i), 1, 0, 0);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      drive(1, 0, 10'h3A0, 0, 1, 0, 0);
      expect_out($sformatf("nest_ret%0d", i), 0, 10'h200, 1, 10'(16 * i + 6), 1, 0, 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 10'(i), 1, 0, 0, 10'(512 + i));
      expect_out($sformatf("refill%0d", i), 0, 10'h200, 1, 10'(512 + i), 1, 0, 0);
    end
    drive(1, 0, 10'h0AA, 1, 0, 0, 10'h0BB);
    expect_out("overflow_call", 0, 10'h200, 0, 10'h000, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    expect_out("overflow_fault", 1, 10'h200, 0, 10'h000, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_out("overflow_drop", 1, 10'h200, 0, 10'h000, 0, 0, 1);
    drive(1, 10'h300, 0, 0, 0, 0, 0);
    expect_out("rerun_accept", 1, 10'h200, 0, 10'h000, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    expect_out("rerun_load_errclr", 1, 10'h300, 0, 10'h000, 1, 0, 0);

    // Three calls deep, then an asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 10'(768 + i), 1, 0, 0, 10'(32 + i));
      expect_out($sformatf("deep_call%0d", i), 0, 10'h300, 1, 10'(32 + i), 1, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 1, 10'h000, 0, 10'h000, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 10'h080, 0, 0, 0, 0, 0);
    expect_out("post_rst_accept", 1, 10'h000, 0, 10'h000, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    expect_out("post_rst_load", 1, 10'h080, 0, 10'h000, 1, 0, 0);
    drive(1, 0, 10'h080, 1, 0, 0, 10'h0C0);
    expect_out("post_rst_call", 0, 10'h080, 1, 10'h0C0, 1, 0, 0);
    drive(1, 0, 10'h0C0, 0, 1, 0, 0);
    expect_out("post_rst_ret", 0, 10'h080, 1, 10'h081, 1, 0, 0);
    drive(1, 0, 10'h081, 0, 1, 0, 0);
    expect_out("post_rst_underflow", 0, 10'h080, 0, 10'h000, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    expect_out("post_rst_fault", 1, 10'h080, 0, 10'h000, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
